keypad_scanner: RTL and testbench

4x4 matrix keypad scanner. It drives the keypad rows one at a time, samples the columns, debounces each press, and hands a 4-bit key code to the CPU-side I/O logic through a valid/ack handshake. It is the input-side counterpart of the multiplexed 7-segment display path and uses the same time-division scanning scheme. It sits between the board keypad pins and the memory-mapped I/O register read by the single-cycle CPU.

---
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-key debounce and a valid/ack handoff to the CPU.
// Define KEYPAD_COL_SYNC_EN to pass the column pins through a 2-flop synchroniser.
module keypad_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   divCnt_q, divCnt_d;
    logic [1:0]      rowIdx_q, rowNext;
    logic [3:0]      row_q;
    logic [1:0]      capCol_q;
    logic [CW-1:0]   pressCnt_q;
    logic [CW-1:0]   relCnt_q;
    logic [3:0]      keyCode_q;
    logic            keyValid_q;
    logic            held_q;

    logic [3:0]      colS;
    logic [1:0]      colIdx;
    logic            hit;
    logic            tick;
    logic            confirm;

`ifdef KEYPAD_COL_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= col;
            sync2_q <= sync1_q;
        end
    end

    assign colS = sync2_q;
`else
    assign colS = col;
`endif

    assign tick     = (divCnt_q == DW'(SCAN_DIV - 1));
    assign divCnt_d = tick ? '0 : divCnt_q + DW'(1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

    // Lowest-index low column wins when several keys in the driven row are down.
    always_comb begin
        colIdx = 2'd3;
        casez (colS)
            4'b???0: colIdx = 2'd0;
            4'b??01: colIdx = 2'd1;
            4'b?011: colIdx = 2'd2;
            default: colIdx = 2'd3;
        endcase
    end

    assign hit     = ~&colS;
    assign rowNext = rowIdx_q + 2'd1;

    always_comb begin
        confirm = 1'b0;
        if (tick && hit) begin
            case (state_q)
                ST_SCAN:     confirm = (DEBOUNCE == 1);
                ST_DEBOUNCE: confirm = (colIdx == capCol_q) && (pressCnt_q == CW'(DEBOUNCE - 1));
                default:     confirm = 1'b0;
            endcase
        end
    end

    // A confirmation always beats a same-cycle ack so the newest key is never lost.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_SCAN;
            rowIdx_q   <= 2'd0;
            row_q      <= 4'b1110;
            capCol_q   <= 2'd0;
            pressCnt_q <= '0;
            relCnt_q   <= '0;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            if (tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (hit) begin
                            capCol_q   <= colIdx;
                            pressCnt_q <= CW'(1);
                            state_q    <= confirm ? ST_HELD : ST_DEBOUNCE;
                        end else begin
                            rowIdx_q <= rowNext;
                            row_q    <= ~(4'b0001 << rowNext);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (hit && colIdx == capCol_q) begin
                            pressCnt_q <= pressCnt_q + CW'(1);
                            if (confirm) begin
                                state_q <= ST_HELD;
                            end
                        end else begin
                            state_q  <= ST_SCAN;
                            rowIdx_q <= rowNext;
                            row_q    <= ~(4'b0001 << rowNext);
                        end
                    end
                    ST_HELD: begin
                        if (hit) begin
                            relCnt_q <= '0;
                        end else if (relCnt_q == CW'(DEBOUNCE - 1)) begin
                            relCnt_q <= '0;
                            held_q   <= 1'b0;
                            state_q  <= ST_SCAN;
                            rowIdx_q <= rowNext;
                            row_q    <= ~(4'b0001 << rowNext);
                        end else begin
                            relCnt_q <= relCnt_q + CW'(1);
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end

            if (confirm) begin
                keyCode_q  <= {rowIdx_q, colIdx};
                keyValid_q <= 1'b1;
                held_q     <= 1'b1;
                relCnt_q   <= '0;
            end else if (keyValid_q && key_ack) begin
                keyValid_q <= 1'b0;
            end
        end
    end

    assign row       = row_q;
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign held      = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a simulated key matrix
// and a tick-level behavioural reference model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
`ifdef KEYPAD_COL_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  colDrv;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        ack;
    logic        held;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain counters driven by the scanning rules.
    int         mDiv, mMode, mPress, mRel;
    logic [1:0] mRow, mCapCol, mC;
    logic [3:0] mCode, mSmp, sh1, sh2, expRow;
    bit         mValid, mHeld, mConf;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .clr       (clr),
        .row       (row),
        .col       (colDrv),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (ack),
        .held      (held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Key matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        colDrv = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) colDrv[c] = 1'b0;
    end

    function automatic logic [3:0] colFor(logic [1:0] r);
        logic [3:0] v;
        v = 4'hF;
        for (int c = 0; c < 4; c++)
            if (keys[int'(r)*4+c]) v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [1:0] lowestLow(logic [3:0] s);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--)
            if (!s[i]) idx = 2'(i);
        return idx;
    endfunction

    assign expRow = ~(4'b0001 << mRow);

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mDiv = 0; mRow = 0; mMode = 0; mPress = 0; mRel = 0; mCapCol = 0;
            mCode = 0; mValid = 0; mHeld = 0; sh1 = 4'hF; sh2 = 4'hF;
        end else begin
            mConf = 0;
            mSmp = SYNC ? sh2 : colFor(mRow);
            if (SYNC) begin
                sh2 = sh1;
                sh1 = colFor(mRow);
            end
            if (mDiv == SCAN_DIV - 1) begin
                mDiv = 0;
                mC = lowestLow(mSmp);
                if (mMode == 0) begin
                    if (mSmp != 4'hF) begin
                        mCapCol = mC;
                        mPress = 1;
                        if (mPress >= DEBOUNCE) mConf = 1; else mMode = 1;
                    end else mRow = mRow + 2'd1;
                end else if (mMode == 1) begin
                    if (mSmp != 4'hF && mC == mCapCol) begin
                        mPress++;
                        if (mPress == DEBOUNCE) mConf = 1;
                    end else begin
                        mMode = 0;
                        mRow = mRow + 2'd1;
                    end
                end else begin
                    if (mSmp != 4'hF) mRel = 0; else mRel++;
                    if (mRel == DEBOUNCE) begin
                        mRel = 0; mHeld = 0; mMode = 0; mRow = mRow + 2'd1;
                    end
                end
            end else mDiv++;
            if (mConf) begin
                mCode = {mRow, mCapCol};
                mValid = 1; mHeld = 1; mMode = 2; mRel = 0;
            end else if (ack && mValid) mValid = 0;
        end
    end

    // True when the coming clock edge confirms a key, evaluated with the inputs already applied.
    function automatic bit predictConfirm();
        logic [3:0] s;
        s = SYNC ? sh2 : colFor(mRow);
        if (mDiv != SCAN_DIV - 1 || s == 4'hF) return 1'b0;
        if (mMode == 0) return DEBOUNCE == 1;
        if (mMode == 1) return (lowestLow(s) == mCapCol) && (mPress + 1 == DEBOUNCE);
        return 1'b0;
    endfunction

    task automatic test_reset();
        clr = 1'b1; ack = 1'b0; keys = 16'h0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (row !== 4'b1110) begin errors++; $display("[TB] FAIL reset_row got %b want 1110", row); end
        if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code got %h want 0", key_code); end
        if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", key_valid); end
        if (held !== 1'b0) begin errors++; $display("[TB] FAIL reset_held got %b want 0", held); end
        clr = 1'b0;
    endtask

    task automatic test_idle();
        int changes = 0;
        logic [3:0] prev;
        prev = row;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row !== prev) changes++;
            prev = row;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL idle_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        checks++;
        if (changes != 10) begin errors++; $display("[TB] FAIL idle_row_steps got %0d want 10", changes); end
    endtask

    task automatic test_bounce();
        bit sawValid = 0;
        for (int i = 0; i < 64; i++) begin
            if (i % SCAN_DIV == 0) keys = keys ^ 16'h0008;
            @(negedge clk);
            if (key_valid) sawValid = 1;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL bounce_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        keys = 16'h0;
        checks++;
        if (sawValid) begin errors++; $display("[TB] FAIL bounce_valid got 1 want 0"); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_press();
        int n = 0;
        keys = 16'h0200;
        while (!key_valid && n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL press_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        checks += 2;
        if (key_code !== 4'h9 || key_valid !== 1'b1) begin errors++; $display("[TB] FAIL press_code got %h/%b want 9/1", key_code, key_valid); end
        if (held !== 1'b1) begin errors++; $display("[TB] FAIL press_held got %b want 1", held); end
        repeat (40 - ((n < 40) ? n : 39)) @(negedge clk);
        keys = 16'h0;
        n = 0;
        while (held && n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL release_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        checks++;
        if (held !== 1'b0 || row !== 4'b0111) begin errors++; $display("[TB] FAIL release_row got held=%b row=%b want held=0 row=0111", held, row); end
    endtask

    task automatic test_handshake();
        int n = 0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_clear got %b want 0", key_valid); end
        keys = 16'h1000;
        while (!key_valid && n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL second_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        checks++;
        if (key_code !== 4'hC || key_valid !== 1'b1) begin errors++; $display("[TB] FAIL second_code got %h/%b want c/1", key_code, key_valid); end
        keys = 16'h0;
        n = 0;
        while (held && n < 200) begin @(negedge clk); n++; end
        keys = 16'h0040;
        n = 0;
        while (!predictConfirm() && n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL coincide_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        checks++;
        if (n >= 200) begin errors++; $display("[TB] FAIL coincide_wait got timeout want confirm"); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (key_code !== 4'h6 || key_valid !== 1'b1) begin errors++; $display("[TB] FAIL coincide_code got %h/%b want 6/1", key_code, key_valid); end
    endtask

    task automatic test_two_keys();
        int n = 0;
        keys = 16'h0;
        while (held && n < 200) begin @(negedge clk); n++; end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        keys = 16'h0050;
        n = 0;
        while (!key_valid && n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL two_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        checks++;
        if (key_code !== 4'h4 || key_valid !== 1'b1) begin errors++; $display("[TB] FAIL two_code got %h/%b want 4/1", key_code, key_valid); end
    endtask

    task automatic test_clr();
        int n = 0;
        keys = 16'h0;
        while (held && n < 200) begin @(negedge clk); n++; end
        keys = 16'h0001;
        n = 0;
        while (mMode != 1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (mMode != 1) begin errors++; $display("[TB] FAIL clr_debounce_wait got timeout want debounce"); end
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({row, key_code, key_valid, held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL clr_debounce got %b/%h/%b/%b want 1110/0/0/0", row, key_code, key_valid, held);
        end
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        while (!held && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (held !== 1'b1 || key_code !== 4'h0) begin errors++; $display("[TB] FAIL clr_held_wait got %b/%h want 1/0", held, key_code); end
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({row, key_code, key_valid, held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL clr_held got %b/%h/%b/%b want 1110/0/0/0", row, key_code, key_valid, held);
        end
        @(negedge clk);
        clr = 1'b0;
        keys = 16'h0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: keys = 16'h0;
                    3: keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                    default: keys = 16'h1 << $urandom_range(0, 15);
                endcase
            end
            ack = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            checks++;
            if ({row, key_code, key_valid, held} !== {expRow, mCode, mValid, mHeld}) begin
                errors++;
                $display("[TB] FAIL random_model got %b/%h/%b/%b want %b/%h/%b/%b", row, key_code, key_valid, held, expRow, mCode, mValid, mHeld);
            end
        end
        ack = 1'b0;
        keys = 16'h0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_bounce();
        test_press();
        test_handshake();
        test_two_keys();
        test_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
